// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding and the x0 register index.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } hazard_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/execute/memory hazard sideband between the pipeline datapath and hazard_ctrl.
interface hazard_ctrl_if;
  import pipeline_pkg::*;

  logic [4:0] addr1DEC;
  logic [4:0] addr2DEC;
  logic       use1DEC;
  logic       use2DEC;
  logic [4:0] rdEXE;
  logic       WregEXE;
  logic       memReadEXE;
  logic       branchTakenEXE;
  logic       memReqMEM;
  logic       memReadyMEM;
  logic       stallIF;
  logic       stallDEC;
  logic       stallEXE;
  logic       stallMEM;
  logic       bubbleEXE;
  logic       flushDEC;
  logic       flushEXE;

  modport master (
    output addr1DEC, addr2DEC, use1DEC, use2DEC, rdEXE, WregEXE, memReadEXE,
           branchTakenEXE, memReqMEM, memReadyMEM,
    input  stallIF, stallDEC, stallEXE, stallMEM, bubbleEXE, flushDEC, flushEXE
  );

  modport slave (
    input  addr1DEC, addr2DEC, use1DEC, use2DEC, rdEXE, WregEXE, memReadEXE,
           branchTakenEXE, memReqMEM, memReadyMEM,
    output stallIF, stallDEC, stallEXE, stallMEM, bubbleEXE, flushDEC, flushEXE
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (inc && (count != {CNT_W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the five-stage core: load-use bubbles, memory-wait freeze, branch flush.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  hazard_ctrl_if.slave     hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] loadUseCnt,
  output logic [CNT_W-1:0] memStallCnt,
  output logic [CNT_W-1:0] flushCnt
`endif
);

  if (CNT_W < 1) begin : gBadCntW
    $error("hazard_ctrl: CNT_W must be at least 1");
  end

  hazard_state_t state, stateNext;
  logic          pendFlush, pendFlushNext;
  logic          loadUse;
  logic          memBusy;
  logic          stallAll, bubble, flush;

  assign memBusy = hz.memReqMEM & ~hz.memReadyMEM;

  assign loadUse = hz.memReadEXE & hz.WregEXE & (hz.rdEXE != REG_ZERO) &
                   ((hz.use1DEC & (hz.addr1DEC == hz.rdEXE)) |
                    (hz.use2DEC & (hz.addr2DEC == hz.rdEXE)));

  always_comb begin
    stateNext     = state;
    pendFlushNext = pendFlush;
    stallAll      = 1'b0;
    bubble        = 1'b0;
    flush         = 1'b0;
    case (state)
      RUN: begin
        if (memBusy) begin
          stallAll  = 1'b1;
          stateNext = MEM_WAIT;
          if (hz.branchTakenEXE)
            pendFlushNext = 1'b1;
        end else if (hz.branchTakenEXE) begin
          // The load-use victim sits in DEC and is squashed, so no bubble is needed.
          flush = 1'b1;
        end else if (loadUse) begin
          bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (memBusy) begin
          stallAll = 1'b1;
          if (hz.branchTakenEXE)
            pendFlushNext = 1'b1;
        end else if (pendFlush || hz.branchTakenEXE) begin
          pendFlushNext = 1'b1;
          stateNext     = FLUSH;
        end else begin
          stateNext = RUN;
        end
      end
      FLUSH: begin
        // A new memory wait outranks the deferred flush; pendFlush survives it.
        if (memBusy) begin
          stallAll  = 1'b1;
          stateNext = MEM_WAIT;
        end else begin
          flush         = 1'b1;
          pendFlushNext = 1'b0;
          stateNext     = RUN;
        end
      end
      default: begin
        stateNext     = RUN;
        pendFlushNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      pendFlush <= 1'b0;
    end else begin
      state     <= stateNext;
      pendFlush <= pendFlushNext;
    end
  end

  assign hz.stallIF   = ~reset & (stallAll | bubble);
  assign hz.stallDEC  = ~reset & (stallAll | bubble);
  assign hz.stallEXE  = ~reset & stallAll;
  assign hz.stallMEM  = ~reset & stallAll;
  assign hz.bubbleEXE = ~reset & bubble;
  assign hz.flushDEC  = ~reset & flush;
  assign hz.flushEXE  = ~reset & flush;

`ifdef HAZARD_PERF_EN
  sat_counter #(.CNT_W(CNT_W)) uLoadUseCnt (
    .clock (clock),
    .reset (reset),
    .inc   (hz.bubbleEXE),
    .count (loadUseCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uMemStallCnt (
    .clock (clock),
    .reset (reset),
    .inc   (hz.stallMEM),
    .count (memStallCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
    .clock (clock),
    .reset (reset),
    .inc   (hz.flushEXE),
    .count (flushCnt)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; counter checks are compiled in with HAZARD_PERF_EN.
module tb_hazard_ctrl;

  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] STALL = 7'b1111000;
  localparam logic [6:0] LU    = 7'b1100100;
  localparam logic [6:0] FL    = 7'b0000011;

  logic clock = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_EN
  logic [31:0] loadUseCnt, memStallCnt, flushCnt;
`endif

  hazard_ctrl #(.CNT_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .hz          (hz.slave)
`ifdef HAZARD_PERF_EN
    ,
    .loadUseCnt  (loadUseCnt),
    .memStallCnt (memStallCnt),
    .flushCnt    (flushCnt)
`endif
  );

  always #5 clock = ~clock;

  logic [6:0] outs;
  assign outs = {hz.stallIF, hz.stallDEC, hz.stallEXE, hz.stallMEM,
                 hz.bubbleEXE, hz.flushDEC, hz.flushEXE};

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic expectOut(input string tag, input logic [6:0] exp);
    #2;
    tests++;
    assert (outs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, outs, exp);
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic expectCnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
`endif

  task automatic clearIn();
    hz.addr1DEC = 5'd0;  hz.addr2DEC = 5'd0;
    hz.use1DEC = 1'b0;   hz.use2DEC = 1'b0;
    hz.rdEXE = 5'd0;     hz.WregEXE = 1'b0;
    hz.memReadEXE = 1'b0; hz.branchTakenEXE = 1'b0;
    hz.memReqMEM = 1'b0; hz.memReadyMEM = 1'b0;
  endtask

  task automatic setLoadUse(input logic [4:0] rd);
    hz.memReadEXE = 1'b1; hz.WregEXE = 1'b1; hz.rdEXE = rd;
    hz.addr2DEC = rd;     hz.use2DEC = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clearIn();
    reset = 1'b1;
    cyc(); cyc();
    hz.memReqMEM = 1'b1; setLoadUse(5'd5);
    expectOut("reset_forces_zero", NONE);
    cyc();

    reset = 1'b0; clearIn();
    expectOut("idle", NONE);
    cyc();

    setLoadUse(5'd5);
    expectOut("loaduse_rs2", LU);
    cyc();
    clearIn();
    expectOut("loaduse_one_cycle", NONE);
    cyc();

    setLoadUse(5'd0);
    expectOut("rd_x0_no_stall", NONE);
    cyc();
    setLoadUse(5'd5); hz.use2DEC = 1'b0;
    expectOut("use2_low_no_stall", NONE);
    cyc();
    clearIn();
    hz.memReadEXE = 1'b1; hz.WregEXE = 1'b1; hz.rdEXE = 5'd7;
    hz.addr1DEC = 5'd7; hz.use1DEC = 1'b1;
    expectOut("loaduse_rs1", LU);
    cyc();
    hz.WregEXE = 1'b0;
    expectOut("wreg_low_no_stall", NONE);
    cyc();

    clearIn(); hz.memReqMEM = 1'b1;
    expectOut("mem_busy_1", STALL);
    cyc();
    expectOut("mem_busy_2", STALL);
    cyc();
    expectOut("mem_busy_3", STALL);
    cyc();
    hz.memReadyMEM = 1'b1;
    expectOut("mem_release", NONE);
`ifdef HAZARD_PERF_EN
    expectCnt("memStallCnt_3", memStallCnt, 32'd3);
    expectCnt("loadUseCnt_2", loadUseCnt, 32'd2);
    expectCnt("flushCnt_0", flushCnt, 32'd0);
`endif
    cyc();
    clearIn(); setLoadUse(5'd9);
    expectOut("back_in_run", LU);
    cyc();

    clearIn(); hz.memReqMEM = 1'b1; hz.branchTakenEXE = 1'b1;
    expectOut("branch_in_wait_1", STALL);
    cyc();
    hz.branchTakenEXE = 1'b0;
    expectOut("branch_in_wait_2", STALL);
    cyc();
    expectOut("branch_in_wait_3", STALL);
    cyc();
    hz.memReadyMEM = 1'b1;
    expectOut("branch_wait_release", NONE);
    cyc();
    clearIn();
    expectOut("deferred_flush", FL);
    cyc();
    expectOut("flush_one_cycle", NONE);
`ifdef HAZARD_PERF_EN
    expectCnt("flushCnt_1", flushCnt, 32'd1);
`endif
    cyc();

    setLoadUse(5'd5); hz.branchTakenEXE = 1'b1;
    expectOut("branch_beats_loaduse", FL);
    cyc();
    clearIn();
    expectOut("after_run_flush", NONE);
    cyc();

    hz.memReqMEM = 1'b1;
    expectOut("release_branch_busy", STALL);
    cyc();
    hz.memReadyMEM = 1'b1; hz.branchTakenEXE = 1'b1;
    expectOut("branch_on_release", NONE);
    cyc();
    clearIn(); hz.memReqMEM = 1'b1;
    expectOut("busy_during_flush", STALL);
    cyc();
    hz.memReadyMEM = 1'b1;
    expectOut("flush_held_release", NONE);
    cyc();
    clearIn();
    expectOut("held_flush_fires", FL);
    cyc();

    hz.memReqMEM = 1'b1; hz.branchTakenEXE = 1'b1;
    expectOut("pend_wait_1", STALL);
    cyc();
    hz.branchTakenEXE = 1'b0; reset = 1'b1;
    expectOut("reset_mid_wait", NONE);
    cyc();
    reset = 1'b0; clearIn();
    expectOut("no_flush_after_reset", NONE);
`ifdef HAZARD_PERF_EN
    expectCnt("loadUseCnt_reset", loadUseCnt, 32'd0);
    expectCnt("memStallCnt_reset", memStallCnt, 32'd0);
    expectCnt("flushCnt_reset", flushCnt, 32'd0);
`endif
    cyc();
    setLoadUse(5'd3);
    expectOut("run_after_reset", LU);
    cyc();
    clearIn();
    expectOut("final_idle", NONE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
